// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
//   l2_arb_state_t : arbiter FSM state (idle, or serving one requester)
//   l2_req_id_t    : requester identity (I-cache, D-cache, prefetcher)
//   LineW          : default cache line width in bits
package l2_arb_pkg;

   localparam int unsigned LineW = 256;

   typedef enum logic [1:0] {
      StIdle,
      StServeI,
      StServeD,
      StServeP
   } l2_arb_state_t;

   typedef enum logic [1:0] {
      ReqI,
      ReqD,
      ReqP
   } l2_req_id_t;

endpackage

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 read/write port between the I-cache miss path, the D-cache
// miss/writeback path and the stride prefetcher. One transaction is outstanding at a
// time; the request is latched on grant and held on the L2 port until l2_resp.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_read/i_addr -> i_rdata/i_resp  I-cache line read and its completion
//   d_read/d_write/d_addr/d_wdata    D-cache line read or writeback
//     -> d_rdata/d_resp
//   pf_read/pf_addr -> pf_resp       speculative prefetch read and its completion
//   l2_read/l2_write/l2_addr/l2_wdata  request to the L2 cache
//   l2_rdata/l2_resp                 L2 read data and completion pulse
//
// Build option: define L2_ARB_STARVE_GUARD_EN to promote the prefetcher after
// STARVE_LIMIT consecutive denials. Without it, P only wins when I and D are idle.
module l2_port_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned LINE_W       = LineW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   input  logic              pf_read,
   input  logic [31:0]       pf_addr,
   output logic              pf_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [31:0]       l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   l2_arb_state_t     state_q, state_d;
   l2_req_id_t        rr_last_q, rr_last_d;
   logic [31:0]       addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;

   logic       d_req;
   logic       grant_vld;
   l2_req_id_t grant_id;
   logic       starve_hit;
   logic       busy;

   assign d_req = d_read | d_write;

`ifdef L2_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

   assign starve_hit = pf_read && (starve_cnt_q == CntW'(STARVE_LIMIT));

   // Counts consecutive idle-cycle arbitrations the waiting prefetch lost; saturates.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!pf_read) begin
         starve_cnt_d = '0;
      end else if (state_q == StIdle && grant_vld) begin
         if (grant_id == ReqP) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q != CntW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   // Arbitration; only acted on in StIdle.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ReqI;
      if (starve_hit) begin
         grant_vld = 1'b1;
         grant_id  = ReqP;
      end else if (i_read && d_req) begin
         grant_vld = 1'b1;
         grant_id  = (rr_last_q == ReqI) ? ReqD : ReqI;
      end else if (i_read) begin
         grant_vld = 1'b1;
         grant_id  = ReqI;
      end else if (d_req) begin
         grant_vld = 1'b1;
         grant_id  = ReqD;
      end else if (pf_read) begin
         grant_vld = 1'b1;
         grant_id  = ReqP;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               unique case (grant_id)
                  ReqI: begin
                     state_d   = StServeI;
                     rr_last_d = ReqI;
                     addr_d    = i_addr;
                     wdata_d   = '0;
                     write_d   = 1'b0;
                  end
                  ReqD: begin
                     state_d   = StServeD;
                     rr_last_d = ReqD;
                     addr_d    = d_addr;
                     wdata_d   = d_wdata;
                     // Read and write together resolve to a single writeback.
                     write_d   = d_write;
                  end
                  default: begin
                     state_d = StServeP;
                     addr_d  = pf_addr;
                     wdata_d = '0;
                     write_d = 1'b0;
                  end
               endcase
            end
         end
         default: begin
            if (l2_resp) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rr_last_q <= ReqI;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign l2_read  = busy & ~write_q;
   assign l2_write = busy & write_q;
   assign l2_addr  = busy ? addr_q : '0;
   assign l2_wdata = busy ? wdata_q : '0;

   // Responses reach only the requester owning the port; l2_resp in idle is dropped.
   assign i_resp  = (state_q == StServeI) & l2_resp;
   assign d_resp  = (state_q == StServeD) & l2_resp;
   assign pf_resp = (state_q == StServeP) & l2_resp;

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 read/write port between three requesters:
  - I-cache miss path (read only).
  - D-cache miss/writeback path (read/write).
  - Stride prefetcher (read only, speculative).
- Sits between the L1 caches/prefetcher and the L2 cache.
- Holds one outstanding transaction at a time, routes the L2 response back only to the granted requester, and keeps the downstream request stable until `l2_resp`.

Parameters:
- `STARVE_LIMIT`, 8: consecutive prefetch denials before promotion. Used only with the optional feature.
- `LINE_W`, 256: cache line data width in bits.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `i_read`  in  1  I-cache line read request
- `i_addr`  in  32  I-cache line address
- `i_rdata`  out  LINE_W  line returned to I-cache
- `i_resp`  out  1  I-cache completion pulse
- `d_read`  in  1  D-cache line read request
- `d_write`  in  1  D-cache line writeback request
- `d_addr`  in  32  D-cache line address
- `d_wdata`  in  LINE_W  writeback data
- `d_rdata`  out  LINE_W  line returned to D-cache
- `d_resp`  out  1  D-cache completion pulse
- `pf_read`  in  1  prefetch line read request
- `pf_addr`  in  32  prefetch address
- `pf_resp`  out  1  prefetch completion pulse
- `l2_read`  out  1  L2 read strobe
- `l2_write`  out  1  L2 write strobe
- `l2_addr`  out  32  L2 address
- `l2_wdata`  out  LINE_W  L2 write data
- `l2_rdata`  in  LINE_W  L2 read data
- `l2_resp`  in  1  L2 completion pulse

Behaviour:
- Reset: state `IDLE`. All outputs 0; `rr_last` = I; `starve_cnt` = 0.
- States: `IDLE`, `SERVE_I`, `SERVE_D`, `SERVE_P`.
- Arbitration (`IDLE` only, evaluated combinationally, registered into state):
  - I and D both requesting: grant the one not equal to `rr_last`.
  - Only one of I/D requesting: grant it.
  - Neither I nor D requesting and `pf_read` high: grant P.
  - Otherwise stay in `IDLE`.
- On grant:
  - Latch address, write data and op (read/write) into registers.
  - Update `rr_last` on I/D grants only.
- `SERVE_x` outputs:
  - `l2_read`/`l2_write`, `l2_addr` and `l2_wdata` are driven from the latched registers and held constant until `l2_resp`.
  - Input changes mid-service are ignored.
- Response routing:
  - `x_resp` = `l2_resp` combinationally, in the granted state only.
  - `i_rdata`/`d_rdata` = `l2_rdata` at all times; they are valid only when the matching resp is high.
  - Non-granted resps stay 0.
- On `l2_resp`: next state `IDLE`.
- Latency:
  - Request seen in `IDLE` at cycle N: `l2_read`/`l2_write` high at N+1.
  - After `l2_resp` at cycle M: earliest next L2 strobe at M+2 (one mandatory `IDLE` cycle).
- `d_read` and `d_write` both high: treated as write; `d_resp` pulses once.
- Requester deasserts after grant: the transaction still completes and the resp still pulses. L2 accesses are never aborted.
- Prefetch request dropped before grant: no L2 access.
- `l2_resp` in `IDLE`: ignored; no resp output.
- Reset mid-transaction: `IDLE` and strobes 0 on the next cycle; the in-flight response is discarded.

Optional Feature:
- Macro: `L2_ARB_STARVE_GUARD_EN`.
- Defined:
  - `starve_cnt` increments in each `IDLE` cycle where `pf_read` is high and I or D is granted.
  - When `starve_cnt` = `STARVE_LIMIT`, P is granted ahead of I/D.
  - `starve_cnt` clears when P is granted or `pf_read` is low.
  - `starve_cnt` saturates; it never wraps.
- Undefined: no counter; P is granted strictly when I/D are idle.

Decomposition:
- Package `l2_arb_pkg`:
  - State enum `l2_arb_state_t`.
  - Requester enum `l2_req_id_t` (I, D, P).
  - Line width constant.
- Sub-module: none required. An optional `l2_arb_starve_ctr` encapsulates the guard counter.

Test Plan:
1. Only `i_read`, `i_addr`=0x0000_1000 at cycle 0; L2 responds 3 cycles after strobe -> `l2_read`=1 with `l2_addr`=0x1000 at cycle 1; `i_resp` pulses with `l2_rdata`; `d_resp`/`pf_resp` stay 0.
2. `i_read` and `d_read` asserted together after reset -> D granted first (`rr_last`=I), then I; no cycle with both strobes high; one `IDLE` cycle between the two accesses.
3. `d_write` to 0x2000 with `d_wdata`=0xA5 repeating; `d_addr` changed to 0x3000 mid-service -> `l2_write`/`l2_addr`=0x2000/`l2_wdata` stable until `l2_resp`; `d_resp` pulses once.
4. `pf_read` 0x4040 with continuous alternating I/D traffic, guard disabled -> no P grant. Guard enabled, `STARVE_LIMIT`=8 -> P granted after 8 denials; `pf_resp` pulses.
5. `rst` asserted while in `SERVE_D` -> next cycle `l2_read`/`l2_write`=0, state `IDLE`; a late `l2_resp` produces no `d_resp`.
6. `pf_read` granted, then deasserted before `l2_resp` -> access completes; `pf_resp` pulses; then `IDLE`.
